// File: rtl/tap_pkg.sv
// Constants shared across the TapTempo chain (period averager and BPM converter).
package tap_pkg;

    localparam int BPM_PER_MAX  = 62600;
    localparam int PER_WIDTH_DEF = 16;
    localparam int AVG_LOG2_DEF  = 2;

    typedef enum logic {
        ST_IDLE,
        ST_COUNT
    } tap_state_t;

endpackage

// File: rtl/tap_hist_ring.sv
// History ring of the last 2^LOG2 tap intervals; oldest is the slot about to be overwritten.
module tap_hist_ring #(
    parameter int WIDTH = 16,
    parameter int LOG2  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] oldest
);

    localparam int DEPTH = 1 << LOG2;
    localparam int PTR_W = (LOG2 > 0) ? LOG2 : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (we) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
    end

    // Entries need no reset: the fill count in the parent tracks which are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign oldest = mem[wr_ptr];

endmodule

// File: rtl/tap_period_avg.sv
// Measures tap-to-tap intervals in tp_i units and outputs the running average of the last
// 2^AVG_LOG2 valid intervals; a saturated interval is a timeout that clears the history.
module tap_period_avg
    import tap_pkg::*;
#(
    parameter int PER_WIDTH = PER_WIDTH_DEF,
    parameter int PER_MAX   = BPM_PER_MAX,
    parameter int PER_MIN   = 1,
    parameter int AVG_LOG2  = AVG_LOG2_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tp_i,
    input  logic                btn_i,
    output logic [PER_WIDTH-1:0] per_o,
    output logic                per_valid_o,
    output logic                timeout_o,
    output logic [AVG_LOG2:0]   fill_o
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = PER_WIDTH + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam logic [PER_WIDTH-1:0] MAX_V  = PER_WIDTH'(PER_MAX);
    localparam logic [PER_WIDTH-1:0] MIN_V  = PER_WIDTH'(PER_MIN);
    localparam logic [FILL_W-1:0]    FULL_V = FILL_W'(DEPTH);

    tap_state_t           state, state_nxt;
    logic [PER_WIDTH-1:0] counter, counter_nxt;
    logic [PER_WIDTH-1:0] sample, sample_nxt;
    logic                 push_nxt, push_pend;
    logic                 tmo_nxt;
    logic                 btn_old;
    logic                 rise;
    logic [SUM_W-1:0]     sum, sum_add, sum_nxt;
    logic [FILL_W-1:0]    fill, fill_nxt;
    logic [PER_WIDTH-1:0] oldest;
    logic [PER_WIDTH-1:0] per_nxt;
    logic                 full;

    assign rise = btn_i & ~btn_old;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            counter   <= '0;
            sample    <= '0;
            push_pend <= 1'b0;
            btn_old   <= 1'b0;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            sample    <= sample_nxt;
            push_pend <= push_nxt;
            btn_old   <= btn_i;
        end
    end

    // A rise always wins over a coincident tp_i, including the saturating one.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        sample_nxt  = sample;
        push_nxt    = 1'b0;
        tmo_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                counter_nxt = '0;
                if (rise) begin
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (rise) begin
                    counter_nxt = '0;
                    if (counter >= MIN_V) begin
                        push_nxt   = 1'b1;
                        sample_nxt = counter;
                    end
                end else if (tp_i && (counter < MAX_V)) begin
                    counter_nxt = counter + PER_WIDTH'(1);
                    if (counter == MAX_V - PER_WIDTH'(1)) begin
                        tmo_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    tap_hist_ring #(
        .WIDTH (PER_WIDTH),
        .LOG2  (AVG_LOG2)
    ) u_ring (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (tmo_nxt),
        .we     (push_pend),
        .wdata  (sample),
        .oldest (oldest)
    );

    // Once full, the wrap-around of sum+sample is undone by subtracting oldest.
    always_comb begin
        full     = (fill == FULL_V);
        sum_add  = sum + SUM_W'(sample);
        sum_nxt  = full ? (sum_add - SUM_W'(oldest)) : sum_add;
        fill_nxt = full ? fill : (fill + FILL_W'(1));
        per_nxt  = (fill_nxt == FULL_V) ? sum_nxt[SUM_W-1:AVG_LOG2] : sample;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum         <= '0;
            fill        <= '0;
            per_o       <= '0;
            per_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            per_valid_o <= 1'b0;
            timeout_o   <= tmo_nxt;
            if (tmo_nxt) begin
                sum  <= '0;
                fill <= '0;
            end else if (push_pend) begin
                sum         <= sum_nxt;
                fill        <= fill_nxt;
                per_o       <= per_nxt;
                per_valid_o <= 1'b1;
            end
        end
    end

    assign fill_o = fill;

endmodule
